// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one external 32-bit ALU among NREQ requesters.
// One op in flight at a time; the result returns on a single tagged response channel.
module alu_req_scheduler #(
  parameter int NREQ    = 4,
  parameter int ALU_LAT = 1,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ*4-1:0]    req_opcode,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [3:0]           alu_opcode,
  input  logic [31:0]          alu_result,
  input  logic                 alu_overflow,
  input  logic                 alu_error,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_result,
  output logic                 rsp_overflow,
  output logic                 rsp_error,
  output logic                 busy,
  output logic [7:0]           err_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [31:0]    alu_a_q, alu_a_d;
  logic [31:0]    alu_b_q, alu_b_d;
  logic [3:0]     alu_opcode_q, alu_opcode_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]    rsp_result_q, rsp_result_d;
  logic           rsp_overflow_q, rsp_overflow_d;
  logic           rsp_error_q, rsp_error_d;
  logic [7:0]     err_count_q, err_count_d;

  logic           hi_found, lo_found, grant_found;
  logic [IDW-1:0] hi_id, lo_id, grant_id;
  logic [31:0]    sel_a, sel_b;
  logic [3:0]     sel_op;

  // Winner search: first valid at or above rr_ptr, else first valid overall (wraparound).
  always_comb begin
    hi_found = 1'b0;
    hi_id    = '0;
    lo_found = 1'b0;
    lo_id    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_id    = IDW'(i);
      end else begin
        lo_found = lo_found;
      end
      if (req_valid[i] && !hi_found && (i >= int'(rr_ptr_q))) begin
        hi_found = 1'b1;
        hi_id    = IDW'(i);
      end else begin
        hi_found = hi_found;
      end
    end
    grant_found = hi_found | lo_found;
    grant_id    = hi_found ? hi_id : lo_id;
    sel_a  = 32'd0;
    sel_b  = 32'd0;
    sel_op = 4'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == grant_id) begin
        sel_a  = req_a[32*i +: 32];
        sel_b  = req_b[32*i +: 32];
        sel_op = req_opcode[4*i +: 4];
      end else begin
        sel_op = sel_op;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= '0;
      cnt_q          <= 4'd0;
      alu_a_q        <= 32'd0;
      alu_b_q        <= 32'd0;
      alu_opcode_q   <= 4'd0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= '0;
      rsp_result_q   <= 32'd0;
      rsp_overflow_q <= 1'b0;
      rsp_error_q    <= 1'b0;
      err_count_q    <= 8'd0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      cnt_q          <= cnt_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_opcode_q   <= alu_opcode_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_result_q   <= rsp_result_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_error_q    <= rsp_error_d;
      err_count_q    <= err_count_d;
    end
  end

  // Next state and datapath: accept in IDLE, count down ALU latency, hold response until taken.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    cnt_d          = cnt_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_opcode_d   = alu_opcode_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_id_d       = rsp_id_q;
    rsp_result_d   = rsp_result_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_error_d    = rsp_error_q;
    err_count_d    = err_count_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          alu_a_d      = sel_a;
          alu_b_d      = sel_b;
          alu_opcode_d = sel_op;
          rsp_id_d     = grant_id;
          rr_ptr_d     = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
          cnt_d        = 4'(ALU_LAT);
          state_d      = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rsp_result_d   = alu_result;
          rsp_overflow_d = alu_overflow;
          rsp_error_d    = alu_error;
          rsp_valid_d    = 1'b1;
          state_d        = S_RESP;
          if (alu_error && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
          end else begin
            err_count_d = err_count_q;
          end
        end else begin
          state_d = S_EXEC;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Grant is only offered from IDLE and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    busy      = (state_q != S_IDLE);
    for (int i = 0; i < NREQ; i++) begin
      if ((state_q == S_IDLE) && grant_found && !rst && (IDW'(i) == grant_id)) begin
        req_ready[i] = 1'b1;
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_opcode   = alu_opcode_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_error    = rsp_error_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed bench for alu_req_scheduler: one instance with ALU_LAT=1, one with ALU_LAT=3.
// ALU model: add; overflow on signed overflow; error = overflow when opcode is 1.
module tb_alu_req_scheduler;

  logic         clk = 1'b0;
  logic         rst, rst3;
  logic [3:0]   req_valid, req_valid3;
  logic [127:0] req_a, req_b;
  logic [15:0]  req_opcode;
  logic         rsp_ready;

  logic [3:0]  req_ready, req_ready3;
  logic [31:0] alu_a, alu_b, alu_result, alu_a3, alu_b3, alu_result3;
  logic [3:0]  alu_opcode, alu_opcode3;
  logic        alu_overflow, alu_error, alu_overflow3, alu_error3;
  logic        rsp_valid, rsp_overflow, rsp_error, busy;
  logic        rsp_valid3, rsp_overflow3, rsp_error3, busy3;
  logic [1:0]  rsp_id, rsp_id3;
  logic [31:0] rsp_result, rsp_result3;
  logic [7:0]  err_count, err_count3;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] res;
    logic        ov;
    logic        er;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   exp_errs = 0;

  always #5 clk = ~clk;

  assign alu_result    = alu_a + alu_b;
  assign alu_overflow  = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
  assign alu_error     = alu_overflow && (alu_opcode == 4'd1);
  assign alu_result3   = alu_a3 + alu_b3;
  assign alu_overflow3 = (alu_a3[31] == alu_b3[31]) && (alu_result3[31] != alu_a3[31]);
  assign alu_error3    = alu_overflow3 && (alu_opcode3 == 4'd1);

  alu_req_scheduler #(.NREQ(4), .ALU_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_error(alu_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_error(rsp_error),
    .busy(busy), .err_count(err_count)
  );

  alu_req_scheduler #(.NREQ(4), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_opcode(alu_opcode3),
    .alu_result(alu_result3), .alu_overflow(alu_overflow3), .alu_error(alu_error3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_id(rsp_id3),
    .rsp_result(rsp_result3), .rsp_overflow(rsp_overflow3), .rsp_error(rsp_error3),
    .busy(busy3), .err_count(err_count3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic exp_t ref_op(input int gid);
    exp_t e;
    logic [31:0] a, b;
    a      = req_a[32*gid +: 32];
    b      = req_b[32*gid +: 32];
    e.id   = 2'(gid);
    e.res  = a + b;
    e.ov   = (a[31] == b[31]) && (e.res[31] != a[31]);
    e.er   = e.ov && (req_opcode[4*gid +: 4] == 4'd1);
    return e;
  endfunction

  // Offer the current request set, expect requester gid to win, then drain its response.
  task automatic serve(input int gid);
    exp_t e;
    int   n;
    #1;
    check("grant_onehot", 32'(req_ready), 32'd1 << gid);
    sb.push_back(ref_op(gid));
    cyc();
    n = 0;
    while (!rsp_valid && n < 20) begin
      cyc();
      n++;
    end
    check("rsp_arrives", 32'(rsp_valid), 32'd1);
    e = sb.pop_front();
    if (e.er && exp_errs < 255) exp_errs++;
    check("rsp_id", 32'(rsp_id), 32'(e.id));
    check("rsp_result", rsp_result, e.res);
    check("rsp_overflow", 32'(rsp_overflow), 32'(e.ov));
    check("rsp_error", 32'(rsp_error), 32'(e.er));
    check("err_count", 32'(err_count), 32'(exp_errs));
    cyc();
    check("rsp_cleared", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    exp_t e;
    int   n;
    int   order[6] = '{0, 1, 2, 3, 0, 1};

    rst = 1'b1; rst3 = 1'b1;
    req_valid = 4'h0; req_valid3 = 4'h0; rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32]     = 32'(i * 1000) - 32'd1500;
      req_b[32*i +: 32]     = 32'(i * 7 + 3);
      req_opcode[4*i +: 4]  = 4'd0;
    end

    // Reset with every requester asserting
    req_valid = 4'hF;
    repeat (2) cyc();
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'h1);
    req_valid = 4'h0;
    cyc();
    check("no_grant_dropped", 32'(busy), 32'd0);

    // Single op from requester 2: 5 + -3
    req_a[64 +: 32] = 32'd5;
    req_b[64 +: 32] = 32'hFFFF_FFFD;
    req_valid = 4'b0100;
    #1;
    check("single_ready", 32'(req_ready), 32'h4);
    sb.push_back(ref_op(2));
    cyc();
    req_valid = 4'h0;
    check("single_alu_a", alu_a, 32'd5);
    check("single_alu_b", alu_b, 32'hFFFF_FFFD);
    check("single_busy", 32'(busy), 32'd1);
    check("single_exec_ready", 32'(req_ready), 32'd0);
    check("single_c1_rsp_valid", 32'(rsp_valid), 32'd0);
    cyc();
    check("single_c2_rsp_valid", 32'(rsp_valid), 32'd1);
    e = sb.pop_front();
    check("single_id", 32'(rsp_id), 32'(e.id));
    check("single_result", rsp_result, 32'd2);
    check("single_model", rsp_result, e.res);
    check("single_overflow", 32'(rsp_overflow), 32'd0);
    rsp_ready = 1'b1;
    cyc();
    check("single_done_valid", 32'(rsp_valid), 32'd0);
    check("single_done_busy", 32'(busy), 32'd0);
    check("alu_a_held", alu_a, 32'd5);

    // Fairness from a fresh pointer with all requesters active
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    exp_errs = 0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    foreach (order[k]) serve(order[k]);
    req_valid = 4'h0;

    // Backpressure: pointer now at 2, only requester 1 asks first
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    check("bp_ready", 32'(req_ready), 32'h2);
    e = ref_op(1);
    cyc();
    req_valid = 4'hF;
    n = 0;
    while (!rsp_valid && n < 20) begin
      cyc();
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_id", 32'(rsp_id), 32'd1);
      check("bp_result", rsp_result, e.res);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      cyc();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_still_valid", 32'(rsp_valid), 32'd1);
    cyc();
    req_valid = 4'h0;
    check("bp_accepted", 32'(rsp_valid), 32'd0);
    check("bp_idle", 32'(busy), 32'd0);

    // Reset in EXEC on the ALU_LAT=3 instance
    rst3 = 1'b0;
    req_valid3 = 4'b0100;
    #1;
    check("l3_ready", 32'(req_ready3), 32'h4);
    cyc();
    check("l3_busy", 32'(busy3), 32'd1);
    cyc();
    rst3 = 1'b1;
    req_valid3 = 4'hF;
    cyc();
    check("l3_rst_busy", 32'(busy3), 32'd0);
    check("l3_rst_alu_a", alu_a3, 32'd0);
    rst3 = 1'b0;
    #1;
    check("l3_rearb_ready", 32'(req_ready3), 32'h1);
    req_valid3 = 4'h0;
    n = 0;
    repeat (8) begin
      cyc();
      if (rsp_valid3) n++;
    end
    check("l3_no_rsp", 32'(n), 32'd0);
    req_valid3 = 4'b0001;
    #1;
    check("l3_grant0", 32'(req_ready3), 32'h1);
    e = ref_op(0);
    cyc();
    req_valid3 = 4'h0;
    n = 1;
    while (!rsp_valid3 && n < 20) begin
      cyc();
      n++;
    end
    check("l3_latency", 32'(n), 32'd4);
    check("l3_id", 32'(rsp_id3), 32'd0);
    check("l3_result", rsp_result3, e.res);
    cyc();
    check("l3_done", 32'(rsp_valid3), 32'd0);

    // Error saturation on the main instance
    req_a[96 +: 32]   = 32'h7FFF_FFFF;
    req_b[96 +: 32]   = 32'd1;
    req_opcode[12 +: 4] = 4'd1;
    req_valid = 4'b1000;
    rsp_ready = 1'b1;
    repeat (300) serve(3);
    req_valid = 4'h0;
    check("sat_err_count", 32'(err_count), 32'd255);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
